// File: rtl/dds_seq_ctrl.sv
// DDS burst sequencer: runs burst_num counter sweeps 0..CNT_MAX separated by
// GAP_LEN idle cycles, with a phase-reset window and a completion pulse.
module dds_seq_ctrl #(
  parameter logic [7:0] CNT_MAX   = 8'd96,
  parameter logic [7:0] RST_START = 8'd10,
  parameter logic [7:0] RST_END   = 8'd14,
  parameter logic [7:0] GAP_LEN   = 8'd20
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] burst_num,
  output logic [7:0] count,
  output logic       state_start,
  output logic       dds_rst,
  output logic [7:0] burst_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] burst_idx_q, burst_idx_d;
  logic [7:0] burst_num_q, burst_num_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       state_start_q, state_start_d;
  logic       dds_rst_q, dds_rst_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    burst_idx_d = burst_idx_q;
    burst_num_d = burst_num_q;
    gap_cnt_d   = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort && (burst_num != 8'd0)) begin
          state_d     = RUN;
          count_d     = '0;
          burst_idx_d = '0;
          burst_num_d = burst_num;
        end
      end
      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          count_d     = '0;
          burst_idx_d = '0;
        end else if (count_q == CNT_MAX) begin
          count_d   = '0;
          gap_cnt_d = '0;
          state_d   = ((burst_idx_q + 8'd1) == burst_num_q) ? DONE : GAP;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d     = IDLE;
          count_d     = '0;
          burst_idx_d = '0;
        end else if (gap_cnt_q == (GAP_LEN - 8'd1)) begin
          state_d     = RUN;
          count_d     = '0;
          burst_idx_d = burst_idx_q + 8'd1;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        count_d     = '0;
        burst_idx_d = '0;
      end
      default: begin
        state_d     = IDLE;
        count_d     = '0;
        burst_idx_d = '0;
      end
    endcase

    // Outputs are derived from the next state so they register in step with it.
    state_start_d = (state_d == RUN);
    dds_rst_d     = (state_d == RUN) && (count_d >= RST_START) && (count_d <= RST_END);
    busy_d        = (state_d == RUN) || (state_d == GAP);
    done_d        = (state_d == DONE);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      burst_idx_q   <= '0;
      burst_num_q   <= '0;
      gap_cnt_q     <= '0;
      state_start_q <= 1'b0;
      dds_rst_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      burst_idx_q   <= burst_idx_d;
      burst_num_q   <= burst_num_d;
      gap_cnt_q     <= gap_cnt_d;
      state_start_q <= state_start_d;
      dds_rst_q     <= dds_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign count       = count_q;
  assign state_start = state_start_q;
  assign dds_rst     = dds_rst_q;
  assign burst_idx   = burst_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// Directed bench for dds_seq_ctrl with default parameters: a vector table for
// short control cases plus hand-written multi-cycle burst sequences.
module tb_dds_seq_ctrl;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] burst_num;
  logic [7:0] count;
  logic       state_start;
  logic       dds_rst;
  logic [7:0] burst_idx;
  logic       busy;
  logic       done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  dds_seq_ctrl #(
    .CNT_MAX  (8'd96),
    .RST_START(8'd10),
    .RST_END  (8'd14),
    .GAP_LEN  (8'd20)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .burst_num  (burst_num),
    .count      (count),
    .state_start(state_start),
    .dds_rst    (dds_rst),
    .burst_idx  (burst_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] bnum;
    logic       ss;
    logic       busy;
    logic       done;
    logic       dds;
    logic [7:0] count;
    logic [7:0] idx;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ss, input logic bz, input logic dn,
                            input logic dr, input logic [7:0] cnt, input logic [7:0] idx);
    check({tag, ".state_start"}, state_start, ss);
    check({tag, ".busy"}, busy, bz);
    check({tag, ".done"}, done, dn);
    check({tag, ".dds_rst"}, dds_rst, dr);
    check({tag, ".count"}, count, cnt);
    check({tag, ".burst_idx"}, burst_idx, idx);
  endtask

  // Checks one full RUN burst starting at count 0; leaves time at the cycle after count 96.
  task automatic run_burst(input string tag, input logic [7:0] idx);
    for (int i = 0; i <= 96; i++) begin
      check_outs(tag, 1'b1, 1'b1, 1'b0, (i >= 10 && i <= 14), 8'(i), idx);
      tick();
    end
  endtask

  task automatic run_gap(input string tag, input logic [7:0] idx);
    for (int g = 0; g < 20; g++) begin
      check_outs(tag, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, idx);
      tick();
    end
  endtask

  initial begin
    int unsigned dds_cycles;
    int unsigned done_seen;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; burst_num = 8'd0;

    //            rst start abort bnum  ss busy done dds count idx
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};

    for (int v = 0; v < 15; v++) begin
      rst_n = vecs[v].rst_n; start = vecs[v].start;
      abort = vecs[v].abort; burst_num = vecs[v].bnum;
      tick();
      check_outs($sformatf("vec%0d", v), vecs[v].ss, vecs[v].busy, vecs[v].done,
                 vecs[v].dds, vecs[v].count, vecs[v].idx);
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    tick();

    // Single burst: dds_rst must be high for exactly 5 cycles.
    burst_num = 8'd1; start = 1'b1; tick(); start = 1'b0;
    dds_cycles = 0;
    for (int i = 0; i <= 96; i++) begin
      if (dds_rst) dds_cycles++;
      check_outs("single", 1'b1, 1'b1, 1'b0, (i >= 10 && i <= 14), 8'(i), 8'd0);
      tick();
    end
    check("single.dds_cycles", dds_cycles, 5);
    check_outs("single.done", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    tick();
    check_outs("single.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // Three bursts with two gaps; done lands at T+332.
    burst_num = 8'd3; start = 1'b1; tick(); start = 1'b0; burst_num = 8'd0;
    run_burst("multi.b0", 8'd0);
    run_gap("multi.g0", 8'd0);
    run_burst("multi.b1", 8'd1);
    run_gap("multi.g1", 8'd1);
    run_burst("multi.b2", 8'd2);
    check("multi.done", done, 1);
    check("multi.done_busy", busy, 0);
    tick();
    check_outs("multi.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // Abort at count 50 of burst 1.
    burst_num = 8'd3; start = 1'b1; tick(); start = 1'b0;
    run_burst("abort.b0", 8'd0);
    run_gap("abort.g0", 8'd0);
    for (int i = 0; i < 50; i++) tick();
    check("abort.pre_count", count, 50);
    check("abort.pre_idx", burst_idx, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check_outs("abort.post", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    done_seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (done || state_start) done_seen++;
      tick();
    end
    check("abort.no_done", done_seen, 0);

    // Start with burst_num=5 during a 1-burst run is ignored.
    burst_num = 8'd1; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("ign.count30", count, 30);
    burst_num = 8'd5; start = 1'b1; tick(); start = 1'b0;
    for (int i = 31; i <= 96; i++) begin
      check("ign.count", count, i);
      check("ign.idx", burst_idx, 0);
      tick();
    end
    check_outs("ign.done", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    done_seen = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    check("ign.no_more", done_seen, 0);

    // Reset at count 40, then restart on the first cycle after release.
    burst_num = 8'd1; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("rstmid.count40", count, 40);
    rst_n = 1'b0; tick();
    check_outs("rstmid.reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    rst_n = 1'b1; start = 1'b1; tick(); start = 1'b0;
    check_outs("rstmid.restart", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    tick();
    check("rstmid.count1", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_seq_ctrl.md
DDS_SEQ_CTRL -- requirements
Module: dds_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_MAX, default 8'd96, meaning the terminal count of one DDS burst.
REQ-002 SHALL have parameter RST_START, default 8'd10, meaning the first count value with dds_rst asserted.
REQ-003 SHALL have parameter RST_END, default 8'd14, meaning the last count value with dds_rst asserted.
REQ-004 SHALL have parameter GAP_LEN, default 8'd20, meaning the idle cycles between consecutive bursts.
REQ-005 SHALL require RST_START <= RST_END < CNT_MAX and GAP_LEN >= 1; other values are unsupported.
REQ-006 SHALL have port clk_sys  input  1  system clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port start  input  1  one-cycle request to begin a burst sequence.
REQ-009 SHALL have port abort  input  1  level request to terminate the sequence.
REQ-010 SHALL have port burst_num  input  8  number of bursts to run, sampled only with an accepted start.
REQ-011 SHALL have port count  output  8  burst cycle counter (drives the DDS decoder).
REQ-012 SHALL have port state_start  output  1  high while a burst is running.
REQ-013 SHALL have port dds_rst  output  1  DDS phase-reset window.
REQ-014 SHALL have port burst_idx  output  8  index of the current burst, 0-based.
REQ-015 SHALL have port busy  output  1  high in states RUN and GAP.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN, GAP and DONE, with every output registered.
REQ-018 SHALL, in IDLE, move to RUN on start=1 with burst_num!=0: latch burst_num, set count=0 and burst_idx=0; RUN and count=0 are visible the cycle after start.
REQ-019 SHALL ignore start in IDLE when burst_num==0 (no state change, no done).
REQ-020 SHALL ignore start in RUN, GAP or DONE; burst_num changes after acceptance SHALL have no effect.
REQ-021 SHALL, in RUN, increment count by 1 each cycle from 0 to CNT_MAX, so RUN lasts CNT_MAX+1 cycles per burst.
REQ-022 SHALL, at count==CNT_MAX in RUN, go to DONE if burst_idx+1 equals the latched burst_num; otherwise it SHALL go to GAP.
REQ-023 SHALL, in GAP, hold count=0 and state_start=0 for exactly GAP_LEN cycles, then enter RUN with count=0 and burst_idx incremented by 1.
REQ-024 SHALL, in DONE, assert done for exactly one cycle with count=0 and busy=0, then return to IDLE.
REQ-025 SHALL drive state_start=1 exactly in the cycles where the state is RUN.
REQ-026 SHALL drive dds_rst=1 exactly in the RUN cycles where RST_START <= count <= RST_END, and 0 otherwise.
REQ-027 SHALL give abort=1 priority over all other events in RUN, GAP or DONE: next cycle state IDLE, count=0, burst_idx=0, state_start=0, dds_rst=0, done=0.
REQ-028 SHALL ignore abort in IDLE; when abort and start are both 1 in IDLE, the start SHALL be rejected.
REQ-029 SHALL never let count exceed CNT_MAX and never let burst_idx exceed latched burst_num-1; no wrap-around occurs.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, force state IDLE and count, burst_idx, state_start, dds_rst, busy and done to 0, overriding start and abort.
REQ-031 SHALL apply reset mid-sequence with no completion pulse, and SHALL accept a new start on the first cycle after rst_n returns to 1.

Verification
REQ-032 SHALL cover reset: rst_n=0 for 3 cycles with start=1 -> all outputs 0 and no RUN entry.
REQ-033 SHALL cover a single burst: burst_num=1, start at cycle T -> state_start high T+1..T+97, count 0..96, dds_rst high for 5 cycles (count 10..14), done=1 at T+98 only, busy=0 at T+98.
REQ-034 SHALL cover multiple bursts: burst_num=3, start at cycle T -> burst_idx 0,1,2, two 20-cycle gaps with count=0, done=1 at T+332 only.
REQ-035 SHALL cover abort: burst_num=3, abort at count=50 of burst_idx=1 -> next cycle IDLE, all outputs 0, no done pulse ever.
REQ-036 SHALL cover ignored starts: start with burst_num=0 -> stays IDLE; start plus burst_num=5 at count=30 of a 1-burst run -> sequence ends after 1 burst.
REQ-037 SHALL cover reset mid-run: rst_n=0 at count=40 -> outputs 0 next edge; start one cycle after release -> count=0 and state_start=1 on the following cycle.
